// File: rtl/fifo_asy_prog.sv
// Dual-clock FIFO with Gray-coded pointer crossing, programmable almost-full/empty
// thresholds, per-domain fill counts and sticky overflow/underflow flags.
module fifo_asy_prog #(
    parameter int WA          = 3,
    parameter int WD          = 4,
    parameter int AF_TH       = 6,
    parameter int AE_TH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic          wclk,
    input  logic          rclk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [WD-1:0] wdata,
    input  logic          ovf_clr,
    output logic          full,
    output logic          almost_full,
    output logic [WA:0]   wr_count,
    output logic          overflow,
    input  logic          rd_en,
    input  logic          udf_clr,
    output logic [WD-1:0] rdata,
    output logic          rdata_valid,
    output logic          empty,
    output logic          almost_empty,
    output logic [WA:0]   rd_count,
    output logic          underflow
);

    localparam int          DEPTH    = 1 << WA;
    localparam logic [WA:0] FULL_CNT = (WA+1)'(DEPTH);
    localparam logic [WA:0] AF_LVL   = (WA+1)'(AF_TH);
    localparam logic [WA:0] AE_LVL   = (WA+1)'(AE_TH);

    logic [WD-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [WA:0]                  wptr_bin_reg;
    logic [WA:0]                  wptr_gray_reg;
    logic [WA:0]                  wptr_bin_next;
    logic [WA:0]                  wr_count_next;
    logic [SYNC_STAGES-1:0][WA:0] rptr_sync_reg;
    logic [WA:0]                  sync_rptr_gray;
    logic [WA:0]                  sync_rptr_bin;
    logic                         wr_acc;

    assign sync_rptr_gray = rptr_sync_reg[SYNC_STAGES-1];

    // Binary bit i of a Gray word is the XOR of all Gray bits at or above i.
    generate
        for (genvar gi = 0; gi <= WA; gi++) begin : g_rptr_g2b
            assign sync_rptr_bin[gi] = ^sync_rptr_gray[WA:gi];
        end
    endgenerate

    assign wr_acc        = wr_en && !full;
    assign wptr_bin_next = wptr_bin_reg + {{WA{1'b0}}, wr_acc};
    assign wr_count_next = wptr_bin_next - sync_rptr_bin;

    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            wptr_bin_reg  <= '0;
            wptr_gray_reg <= '0;
            rptr_sync_reg <= '0;
            wr_count      <= '0;
            full          <= 1'b0;
            almost_full   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            wptr_bin_reg  <= wptr_bin_next;
            wptr_gray_reg <= wptr_bin_next ^ (wptr_bin_next >> 1);
            rptr_sync_reg <= {rptr_sync_reg[SYNC_STAGES-2:0], rptr_gray_reg};
            wr_count      <= wr_count_next;
            full          <= (wr_count_next == FULL_CNT);
            almost_full   <= (wr_count_next >= AF_LVL);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (rst_n && wr_acc) begin
            mem[wptr_bin_reg[WA-1:0]] <= wdata;
        end
    end

    // ---------------- read domain ----------------
    logic [WA:0]                  rptr_bin_reg;
    logic [WA:0]                  rptr_gray_reg;
    logic [WA:0]                  rptr_bin_next;
    logic [WA:0]                  rd_count_next;
    logic [SYNC_STAGES-1:0][WA:0] wptr_sync_reg;
    logic [WA:0]                  sync_wptr_gray;
    logic [WA:0]                  sync_wptr_bin;
    logic                         rd_acc;

    assign sync_wptr_gray = wptr_sync_reg[SYNC_STAGES-1];

    generate
        for (genvar gi = 0; gi <= WA; gi++) begin : g_wptr_g2b
            assign sync_wptr_bin[gi] = ^sync_wptr_gray[WA:gi];
        end
    endgenerate

    assign rd_acc        = rd_en && !empty;
    assign rptr_bin_next = rptr_bin_reg + {{WA{1'b0}}, rd_acc};
    assign rd_count_next = sync_wptr_bin - rptr_bin_next;

    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            rptr_bin_reg  <= '0;
            rptr_gray_reg <= '0;
            wptr_sync_reg <= '0;
            rd_count      <= '0;
            empty         <= 1'b1;
            almost_empty  <= 1'b1;
            underflow     <= 1'b0;
            rdata_valid   <= 1'b0;
        end else begin
            rptr_bin_reg  <= rptr_bin_next;
            rptr_gray_reg <= rptr_bin_next ^ (rptr_bin_next >> 1);
            wptr_sync_reg <= {wptr_sync_reg[SYNC_STAGES-2:0], wptr_gray_reg};
            rd_count      <= rd_count_next;
            empty         <= (rd_count_next == '0);
            almost_empty  <= (rd_count_next <= AE_LVL);
            rdata_valid   <= rd_acc;
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (udf_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    // Registered RAM read; rdata holds its last popped word between reads.
    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_acc) begin
            rdata <= mem[rptr_bin_reg[WA-1:0]];
        end
    end

endmodule

// File: tb/tb_fifo_asy_prog.sv
// Bench for fifo_asy_prog: queue-based reference model checked every clock in each
// domain, plus directed sequences with literal expectations.
`timescale 1ns/1ps
module tb_fifo_asy_prog;

    logic       wclk = 1'b0;
    logic       rclk = 1'b0;
    logic       rst_n;
    logic       wr_en, ovf_clr, rd_en, udf_clr;
    logic [3:0] wdata;
    logic       full, almost_full, overflow;
    logic [3:0] wr_count, rd_count;
    logic [3:0] rdata;
    logic       rdata_valid, empty, almost_empty, underflow;

    int rhalf = 5;
    int nvec  = 0;
    int nerr  = 0;

    always #10 wclk = ~wclk;
    always #(rhalf) rclk = ~rclk;

    fifo_asy_prog dut (
        .wclk(wclk), .rclk(rclk), .rst_n(rst_n),
        .wr_en(wr_en), .wdata(wdata), .ovf_clr(ovf_clr),
        .full(full), .almost_full(almost_full), .wr_count(wr_count), .overflow(overflow),
        .rd_en(rd_en), .udf_clr(udf_clr),
        .rdata(rdata), .rdata_valid(rdata_valid), .empty(empty),
        .almost_empty(almost_empty), .rd_count(rd_count), .underflow(underflow)
    );

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] q[$];
    int         wr_total = 0;
    int         rd_total = 0;
    logic       ovf_m = 1'b0;
    logic       udf_m = 1'b0;
    logic       valid_m = 1'b0;
    logic [3:0] rdata_m = 4'd0;
    logic       w_rst_s, r_rst_s;

    always @(posedge wclk) begin
        w_rst_s = rst_n;
        if (!rst_n) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            if (wr_en && !full) begin
                q.push_back(wdata);
                wr_total++;
            end
            if (wr_en && full) ovf_m = 1'b1;
            else if (ovf_clr) ovf_m = 1'b0;
        end
        #1;
        check("overflow", overflow, ovf_m);
        check("full_vs_wr_count", full, wr_count == 4'd8);
        check("afull_vs_wr_count", almost_full, wr_count >= 4'd6);
        if (!w_rst_s) check("wr_count_in_reset", wr_count, 0);
        else if (rst_n) check("wr_count_bounds", (wr_count >= q.size()) && (wr_count <= 8), 1);
    end

    always @(posedge rclk) begin
        r_rst_s = rst_n;
        if (!rst_n) begin
            q.delete();
            udf_m   = 1'b0;
            valid_m = 1'b0;
            rdata_m = 4'd0;
        end else begin
            valid_m = 1'b0;
            if (rd_en && !empty) begin
                if (q.size() == 0) begin
                    check("read_from_model_empty", 0, 1);
                end else begin
                    rdata_m = q.pop_front();
                    valid_m = 1'b1;
                    rd_total++;
                end
            end
            if (rd_en && empty) udf_m = 1'b1;
            else if (udf_clr) udf_m = 1'b0;
        end
        #1;
        check("rdata_valid", rdata_valid, valid_m);
        check("rdata", rdata, rdata_m);
        check("underflow", underflow, udf_m);
        check("empty_vs_rd_count", empty, rd_count == 4'd0);
        check("aempty_vs_rd_count", almost_empty, rd_count <= 4'd2);
        if (!r_rst_s) check("rd_count_in_reset", rd_count, 0);
        else if (rst_n) check("rd_count_bound", rd_count <= q.size(), 1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr_pulse(input logic [3:0] d);
        @(negedge wclk);
        wr_en = 1'b1;
        wdata = d;
        @(negedge wclk);
        wr_en = 1'b0;
    endtask

    task automatic rd_pulse();
        @(negedge rclk);
        rd_en = 1'b1;
        @(negedge rclk);
        rd_en = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_full"}, full, 0);
        check({tag, "_almost_full"}, almost_full, 0);
        check({tag, "_wr_count"}, wr_count, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_almost_empty"}, almost_empty, 1);
        check({tag, "_rd_count"}, rd_count, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_rdata_valid"}, rdata_valid, 0);
    endtask

    task automatic stream(input int rh, input string tag);
        int rd_before;
        rhalf = rh;
        repeat (4) @(negedge wclk);
        rd_before = rd_total;
        fork
            begin : writer
                int n   = 0;
                int cyc = 0;
                while (n < 200 && cyc < 5000) begin
                    @(negedge wclk);
                    cyc++;
                    if (!full) begin
                        wr_en = 1'b1;
                        wdata = 4'(n);
                        n++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(negedge wclk);
                wr_en = 1'b0;
                check({tag, "_writes_done"}, n, 200);
            end
            begin : reader
                int got = 0;
                int cyc = 0;
                while (got < 200 && cyc < 10000) begin
                    @(negedge rclk);
                    cyc++;
                    if (!empty) begin
                        rd_en = 1'b1;
                        got++;
                    end else begin
                        rd_en = 1'b0;
                    end
                end
                @(negedge rclk);
                rd_en = 1'b0;
                check({tag, "_reads_done"}, got, 200);
            end
        join
        repeat (10) @(negedge wclk);
        check({tag, "_pops"}, rd_total - rd_before, 200);
        check({tag, "_last_word"}, rdata, 7);
        check({tag, "_no_overflow"}, overflow, 0);
        check({tag, "_no_underflow"}, underflow, 0);
        check({tag, "_empty_after"}, empty, 1);
        check({tag, "_wr_count_after"}, wr_count, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wdata   = 4'd0;
        ovf_clr = 1'b0;
        udf_clr = 1'b0;
        repeat (6) @(negedge wclk);
        check_reset_values("por");
        rst_n = 1'b1;
        repeat (2) @(negedge wclk);

        // Fill with rclk idle
        for (int k = 1; k <= 8; k++) begin
            wr_pulse(4'(k));
            check("fill_wr_count", wr_count, k);
            check("fill_almost_full", almost_full, k >= 6);
            check("fill_full", full, k == 8);
        end
        wr_pulse(4'd9);
        check("ovf_set", overflow, 1);
        check("ovf_wr_count", wr_count, 8);

        // Clear loses to a same-cycle overflowing write, then wins alone
        @(negedge wclk);
        wr_en   = 1'b1;
        wdata   = 4'd9;
        ovf_clr = 1'b1;
        @(negedge wclk);
        check("ovf_set_beats_clr", overflow, 1);
        wr_en = 1'b0;
        @(negedge wclk);
        check("ovf_clr_alone", overflow, 0);
        ovf_clr = 1'b0;

        // Drain at rclk = 2x wclk
        repeat (6) @(negedge rclk);
        check("pre_drain_rd_count", rd_count, 8);
        check("pre_drain_empty", empty, 0);
        check("pre_drain_aempty", almost_empty, 0);
        for (int k = 1; k <= 8; k++) begin
            rd_pulse();
            check("drain_rdata", rdata, k);
            check("drain_valid", rdata_valid, 1);
            check("drain_rd_count", rd_count, 8 - k);
            check("drain_empty", empty, k == 8);
            check("drain_aempty", almost_empty, k >= 6);
        end
        rd_pulse();
        check("udf_set", underflow, 1);
        check("udf_valid_low", rdata_valid, 0);
        check("udf_rdata_hold", rdata, 8);
        @(negedge rclk);
        udf_clr = 1'b1;
        @(negedge rclk);
        udf_clr = 1'b0;
        check("udf_clr", underflow, 0);
        check("drain_pops", rd_total, 8);

        // Continuous traffic, each clock faster in turn
        stream(5, "rfast");
        stream(17, "wfast");
        check("wrap_total_writes", wr_total, 408);

        // Reset mid-operation
        rhalf = 5;
        repeat (4) @(negedge wclk);
        for (int k = 1; k <= 5; k++) wr_pulse(4'(k));
        check("pre_rst_wr_count", wr_count, 5);
        @(negedge wclk);
        rst_n = 1'b0;
        repeat (4) @(negedge wclk);
        check_reset_values("midrst");
        rst_n = 1'b1;
        wr_pulse(4'hA);
        n = 0;
        while (empty && n < 30) begin
            @(negedge rclk);
            n++;
        end
        check("post_rst_visible", empty, 0);
        rd_pulse();
        check("post_rst_rdata", rdata, 10);
        check("post_rst_valid", rdata_valid, 1);

        // Empty-deassert latency
        repeat (6) @(negedge wclk);
        @(negedge wclk);
        wr_en = 1'b1;
        wdata = 4'd3;
        @(posedge wclk);
        #1 wr_en = 1'b0;
        n = 0;
        do begin
            @(posedge rclk);
            #1;
            n++;
        end while (empty && n < 20);
        check("empty_latency_edges", n, 3);
        rd_pulse();
        check("latency_rdata", rdata, 3);
        repeat (6) @(negedge wclk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
